vga_fb_write_buffer: RTL and testbench

- Upstream stage of the VGA display block.
- Captures CPU framebuffer stores from the data bus into a small FIFO so the bus never collides with display reads.
- Drains buffered stores to the framebuffer SRAM write interface only while the display is blanking.
- Lets software write pixels at any time without tearing reads or losing stores.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/vga_fb_write_buffer.sv | 139 +++++++++++++
 tb/tb_vga_fb_write_buffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared geometry, framebuffer write entry type and drain FSM states for the
// VGA display path.
package vga_pkg;

  localparam int VisiblePixels = 640;
  localparam int VisibleLines  = 480;
  localparam int WholeLine     = 800;
  localparam int WholeFrame    = 525;
  localparam int FbPixels      = VisiblePixels * VisibleLines;

  typedef logic [15:0] pixel_t;

  typedef struct packed {
    logic [19:0] addr;
    pixel_t      data;
  } fb_wr_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } wbuf_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO exposing the head and the entry behind it for look-ahead reads.
// With VGA_FB_WBUF_COALESCE_EN an extra port overwrites the most recently pushed entry.
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 16,
  localparam int AddrW = $clog2(Depth),
  localparam int CntW  = AddrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wr_data,
  input  logic             pop,
`ifdef VGA_FB_WBUF_COALESCE_EN
  input  logic             ovr_en,
  input  logic [Width-1:0] ovr_data,
`endif
  output logic [Width-1:0] head_data,
  output logic [Width-1:0] next_data,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wr_ptr;
  logic [AddrW-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CntW'(Depth));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];
  assign next_data = mem[rd_ptr + AddrW'(1)];

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
`ifdef VGA_FB_WBUF_COALESCE_EN
    else if (ovr_en) begin
      mem[wr_ptr - AddrW'(1)] <= ovr_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AddrW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AddrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_fb_write_buffer.sv
// Buffers CPU framebuffer stores and drains them to the SRAM only during blanking.
// Optional store coalescing on the newest entry is enabled by VGA_FB_WBUF_COALESCE_EN.
module vga_fb_write_buffer
  import vga_pkg::*;
#(
  parameter int          WidthPixels  = 640,
  parameter int          HeightPixels = 480,
  parameter logic [31:0] BASEADDRESS  = 32'h4000_0000,
  parameter int          Depth        = 16
) (
  input  logic        ACLK,
  input  logic        RESET,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_I,
  input  logic        WRSTB,
  output logic        STALL,
  input  logic        BLANK,
  output logic [19:0] FB_ADDR,
  output logic [15:0] FB_DATA,
  output logic        FB_WE,
  input  logic        FB_ACK,
  output logic [15:0] DROP_CNT
);

  localparam int          CntW        = $clog2(Depth) + 1;
  localparam logic [31:0] WindowBytes = 32'(WidthPixels * HeightPixels * 4);

  logic [31:0]     offset;
  logic            hit;
  logic [19:0]     pix_idx;
  fb_wr_t          wr_entry;
  fb_wr_t          head_entry;
  fb_wr_t          next_entry;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            push_req;
  logic            pop_req;
  wbuf_state_e     state;
  logic            unused_bits;

  assign offset      = ADDR - BASEADDRESS;
  assign hit         = (offset < WindowBytes) && (ADDR[1:0] == 2'b00);
  assign pix_idx     = offset[21:2];
  assign wr_entry    = '{addr: pix_idx, data: DATA_I[15:0]};
  assign pop_req     = (state == ISSUE) && FB_ACK;
  assign unused_bits = ^{offset[31:22], offset[1:0], DATA_I[31:16]};

`ifdef VGA_FB_WBUF_COALESCE_EN
  logic [19:0] last_idx;
  logic        head_locked;
  logic        coalesce;

  // The newest entry must not be the one already latched (or about to be latched)
  // into the FB_* registers, otherwise the overwrite would be lost.
  assign head_locked = ((fifo_count == CntW'(1)) && ((state == ISSUE) || BLANK)) ||
                       ((fifo_count == CntW'(2)) && pop_req);
  assign coalesce    = WRSTB && hit && !fifo_empty && (pix_idx == last_idx) && !head_locked;
  assign push_req    = WRSTB && hit && !coalesce;
  assign STALL       = fifo_full && !coalesce;

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      last_idx <= '0;
    end else if (push_req && !fifo_full) begin
      last_idx <= pix_idx;
    end
  end
`else
  assign push_req = WRSTB && hit;
  assign STALL    = fifo_full;
`endif

  sync_fifo #(
    .Width($bits(fb_wr_t)),
    .Depth(Depth)
  ) u_fifo (
    .clk       (ACLK),
    .rst       (RESET),
    .push      (push_req),
    .wr_data   (wr_entry),
    .pop       (pop_req),
`ifdef VGA_FB_WBUF_COALESCE_EN
    .ovr_en    (coalesce),
    .ovr_data  (wr_entry),
`endif
    .head_data (head_entry),
    .next_data (next_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // On an ACK the next request is loaded from the entry behind the head, so
  // back-to-back writes need two entries present at the start of the cycle.
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      FB_WE   <= 1'b0;
      FB_ADDR <= '0;
      FB_DATA <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (BLANK && !fifo_empty) begin
            state   <= ISSUE;
            FB_WE   <= 1'b1;
            FB_ADDR <= head_entry.addr;
            FB_DATA <= head_entry.data;
          end
        end
        ISSUE: begin
          if (FB_ACK) begin
            if (BLANK && (fifo_count >= CntW'(2))) begin
              FB_ADDR <= next_entry.addr;
              FB_DATA <= next_entry.data;
            end else begin
              state <= IDLE;
              FB_WE <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          FB_WE <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      DROP_CNT <= '0;
    end else if (WRSTB && !hit && (DROP_CNT != 16'hFFFF)) begin
      DROP_CNT <= DROP_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_fb_write_buffer.sv
// Directed bench for vga_fb_write_buffer; expectations are hand-derived per step.
// Builds with or without VGA_FB_WBUF_COALESCE_EN.
module tb_vga_fb_write_buffer;

  localparam logic [31:0] Base = 32'h4000_0000;

  logic        ACLK   = 1'b0;
  logic        RESET  = 1'b1;
  logic [31:0] ADDR   = '0;
  logic [31:0] DATA_I = '0;
  logic        WRSTB  = 1'b0;
  logic        BLANK  = 1'b0;
  logic        FB_ACK = 1'b0;
  logic        STALL;
  logic [19:0] FB_ADDR;
  logic [15:0] FB_DATA;
  logic        FB_WE;
  logic [15:0] DROP_CNT;

  int compareCount  = 0;
  int mismatchCount = 0;

  always #5 ACLK = ~ACLK;

  vga_fb_write_buffer dut (
    .ACLK     (ACLK),
    .RESET    (RESET),
    .ADDR     (ADDR),
    .DATA_I   (DATA_I),
    .WRSTB    (WRSTB),
    .STALL    (STALL),
    .BLANK    (BLANK),
    .FB_ADDR  (FB_ADDR),
    .FB_DATA  (FB_DATA),
    .FB_WE    (FB_WE),
    .FB_ACK   (FB_ACK),
    .DROP_CNT (DROP_CNT)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic wr, input logic blank, input logic ack);
    ADDR   = addr;
    DATA_I = data;
    WRSTB  = wr;
    BLANK  = blank;
    FB_ACK = ack;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    tick();
    tick();
    checkOutput("rst_we", 32'(FB_WE), 32'h0);
    checkOutput("rst_stall", 32'(STALL), 32'h0);
    checkOutput("rst_addr", 32'(FB_ADDR), 32'h0);
    checkOutput("rst_data", 32'(FB_DATA), 32'h0);
    checkOutput("rst_drop", 32'(DROP_CNT), 32'h0);
    RESET = 1'b0;
    tick();

    // Single store with blanking active: one cycle of latency to FB_WE.
    $display("[TB] single store latency");
    applyStimulus(Base + 32'd8, 32'h0000_7C1F, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus('0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("lat_we_early", 32'(FB_WE), 32'h0);
    tick();
    checkOutput("lat_we", 32'(FB_WE), 32'h1);
    checkOutput("lat_addr", 32'(FB_ADDR), 32'h2);
    checkOutput("lat_data", 32'(FB_DATA), 32'h7C1F);
    applyStimulus('0, '0, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("lat_we_drop", 32'(FB_WE), 32'h0);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);

    // Fill the FIFO during active display, then drain with ACK tied high.
    $display("[TB] fill, stall and drain");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(Base + 32'(4 * i), 32'hDEAD_0100 + 32'(i), 1'b1, 1'b0, 1'b0);
      tick();
      if (i == 14) checkOutput("fill_stall_15", 32'(STALL), 32'h0);
    end
    checkOutput("fill_stall_16", 32'(STALL), 32'h1);
    applyStimulus(Base + 32'd64, 32'h0000_0AAA, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("held_stall", 32'(STALL), 32'h1);
    checkOutput("held_we", 32'(FB_WE), 32'h0);
    applyStimulus(Base + 32'd64, 32'h0000_0AAA, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("drain0_we", 32'(FB_WE), 32'h1);
    checkOutput("drain0_addr", 32'(FB_ADDR), 32'h0);
    checkOutput("drain0_data", 32'(FB_DATA), 32'h0100);
    checkOutput("drain0_stall", 32'(STALL), 32'h1);
    tick();
    checkOutput("drain1_addr", 32'(FB_ADDR), 32'h1);
    checkOutput("drain1_stall", 32'(STALL), 32'h0);
    tick();
    applyStimulus('0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("drain2_addr", 32'(FB_ADDR), 32'h2);
    for (int k = 3; k <= 16; k++) begin
      tick();
      checkOutput("drain_we", 32'(FB_WE), 32'h1);
      checkOutput("drain_addr", 32'(FB_ADDR), 32'(k));
      checkOutput("drain_data", 32'(FB_DATA), (k < 16) ? 32'h0100 + 32'(k) : 32'h0AAA);
    end
    tick();
    checkOutput("drain_end_we", 32'(FB_WE), 32'h0);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);

    // Out-of-window and misaligned stores are counted, never buffered.
    $display("[TB] dropped stores");
    applyStimulus(32'h4012_C000, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("drop_one", 32'(DROP_CNT), 32'h1);
    applyStimulus(Base + 32'd2, 32'h0000_5678, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus('0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("drop_two", 32'(DROP_CNT), 32'h2);
    checkOutput("drop_stall", 32'(STALL), 32'h0);
    repeat (3) tick();
    checkOutput("drop_no_we", 32'(FB_WE), 32'h0);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);

    // BLANK falls mid-request: request held until ACK, then nothing until BLANK rises.
    $display("[TB] blank falling mid-request");
    applyStimulus(Base + 32'd80, 32'h0000_0020, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(Base + 32'd84, 32'h0000_0021, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("mid_we", 32'(FB_WE), 32'h1);
    checkOutput("mid_addr", 32'(FB_ADDR), 32'd20);
    applyStimulus(Base + 32'd88, 32'h0000_0022, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("hold_we", 32'(FB_WE), 32'h1);
      checkOutput("hold_addr", 32'(FB_ADDR), 32'd20);
      checkOutput("hold_data", 32'(FB_DATA), 32'h0020);
    end
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_ack_we", 32'(FB_WE), 32'h0);
    repeat (3) tick();
    checkOutput("pending_no_we", 32'(FB_WE), 32'h0);
    applyStimulus('0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("resume_we", 32'(FB_WE), 32'h1);
    checkOutput("resume_addr", 32'(FB_ADDR), 32'd21);
    applyStimulus('0, '0, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("resume2_addr", 32'(FB_ADDR), 32'd22);
    checkOutput("resume2_data", 32'(FB_DATA), 32'h0022);
    tick();
    checkOutput("resume_end_we", 32'(FB_WE), 32'h0);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while a request is outstanding with entries queued.
    $display("[TB] async reset mid-request");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(Base + 32'(4 * (30 + i)), 32'h0000_0030 + 32'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    applyStimulus('0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("prerst_we", 32'(FB_WE), 32'h1);
    checkOutput("prerst_addr", 32'(FB_ADDR), 32'd30);
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("async_we", 32'(FB_WE), 32'h0);
    checkOutput("async_stall", 32'(STALL), 32'h0);
    checkOutput("async_addr", 32'(FB_ADDR), 32'h0);
    checkOutput("async_data", 32'(FB_DATA), 32'h0);
    checkOutput("async_drop", 32'(DROP_CNT), 32'h0);
    tick();
    tick();
    RESET = 1'b0;
    repeat (3) tick();
    checkOutput("postrst_we", 32'(FB_WE), 32'h0);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);

    // Two stores to the same pixel while the display is active.
    $display("[TB] repeated pixel stores");
    applyStimulus(Base + 32'd28, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(Base + 32'd28, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus('0, '0, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("same_we", 32'(FB_WE), 32'h1);
    checkOutput("same_addr", 32'(FB_ADDR), 32'd7);
`ifdef VGA_FB_WBUF_COALESCE_EN
    checkOutput("coal_data", 32'(FB_DATA), 32'h0002);
    tick();
    checkOutput("coal_end_we", 32'(FB_WE), 32'h0);
`else
    checkOutput("same_data1", 32'(FB_DATA), 32'h0001);
    tick();
    checkOutput("same2_we", 32'(FB_WE), 32'h1);
    checkOutput("same2_addr", 32'(FB_ADDR), 32'd7);
    checkOutput("same2_data", 32'(FB_DATA), 32'h0002);
    tick();
    checkOutput("same_end_we", 32'(FB_WE), 32'h0);
`endif
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
